// File: rtl/datapath_seq.sv
// Self-sequencing datapath: register file, flag-setting ALU and word RAM,
// stepped through READ/EXEC/MEM/WB by an internal controller per start pulse.
module datapath_seq #(
   parameter int DATA_W = 64,
   parameter int REG_AW = 5,
   parameter int RAM_AW = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [REG_AW-1:0] rd,
   input  logic [REG_AW-1:0] ra,
   input  logic [REG_AW-1:0] rb,
   input  logic [DATA_W-1:0] imm,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        flags,
   input  logic [REG_AW-1:0] dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int NREG = 1 << REG_AW;
   localparam int NRAM = 1 << RAM_AW;

   typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MEM, S_WB} state_t;
   typedef enum logic [2:0] {
      OP_LOADI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LD, OP_ST
   } op_t;

   state_t            r_state;
   op_t               r_op;
   logic [REG_AW-1:0] r_rd, r_ra, r_rb;
   logic [DATA_W-1:0] r_imm, r_a, r_b, r_r, r_ram_q;
   logic [DATA_W-1:0] r_regs [NREG];
   logic [DATA_W-1:0] r_ram  [NRAM];

   logic [DATA_W:0]   w_sum, w_diff;
   logic [DATA_W-1:0] w_alu, w_wb;
   logic              w_c, w_v;
   logic [RAM_AW-1:0] w_addr;

   assign w_addr   = r_a[RAM_AW-1:0];
   assign dbg_data = r_regs[dbg_sel];
   assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
   assign w_diff   = {1'b0, r_a} + {1'b0, ~r_b} + (DATA_W+1)'(1);
   // LD data comes straight from the RAM read register rather than via R
   assign w_wb     = (r_op == OP_LD) ? r_ram_q : r_r;

   always_comb begin
      w_alu = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      unique case (r_op)
         OP_ADD: begin
            {w_c, w_alu} = w_sum;
            w_v = (r_a[DATA_W-1] == r_b[DATA_W-1]) && (w_alu[DATA_W-1] != r_a[DATA_W-1]);
         end
         OP_SUB: begin
            {w_c, w_alu} = w_diff;
            w_v = (r_a[DATA_W-1] != r_b[DATA_W-1]) && (w_alu[DATA_W-1] != r_a[DATA_W-1]);
         end
         OP_AND:  w_alu = r_a & r_b;
         OP_OR:   w_alu = r_a | r_b;
         OP_XOR:  w_alu = r_a ^ r_b;
         default: w_alu = r_imm;
      endcase
   end

   // RAM is never reset; an async reset forces IDLE, so an aborted ST cannot write
   always_ff @(posedge clk) begin
      if (r_state == S_MEM) begin
         if (r_op == OP_ST) r_ram[w_addr] <= r_b;
         r_ram_q <= r_ram[w_addr];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_op    <= OP_LOADI;
         r_rd    <= '0;
         r_ra    <= '0;
         r_rb    <= '0;
         r_imm   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_r     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         flags   <= '0;
         for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else begin
         done <= 1'b0;
         unique case (r_state)
            S_IDLE: if (start) begin
               r_op    <= op_t'(op);
               r_rd    <= rd;
               r_ra    <= ra;
               r_rb    <= rb;
               r_imm   <= imm;
               busy    <= 1'b1;
               r_state <= S_READ;
            end
            S_READ: begin
               r_a     <= r_regs[r_ra];
               r_b     <= r_regs[r_rb];
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               r_r <= w_alu;
               if (r_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR})
                  flags <= {w_alu == '0, w_alu[DATA_W-1], w_c, w_v};
               r_state <= (r_op inside {OP_LD, OP_ST}) ? S_MEM : S_WB;
            end
            S_MEM: begin
               if (r_op == OP_ST) r_r <= r_b;
               r_state <= S_WB;
            end
            S_WB: begin
               if (r_op != OP_ST && r_rd != '0) r_regs[r_rd] <= w_wb;
               result  <= w_wb;
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_datapath_seq.sv
// Scoreboard bench for datapath_seq: a bench-side register/RAM/flag model
// predicts each op's result, queued at issue and checked when done pulses.
module tb_datapath_seq;

   logic        clk, rst, start, busy, done;
   logic [2:0]  op;
   logic [4:0]  rd, ra, rb, dbg_sel;
   logic [63:0] imm, result, dbg_data;
   logic [3:0]  flags;

   int checks = 0;
   int errors = 0;

   logic [63:0] m_regs [32];
   logic [63:0] m_ram  [bit [7:0]];
   logic [3:0]  m_flags;
   logic [63:0] q_exp  [$];

   datapath_seq #(.DATA_W(64), .REG_AW(5), .RAM_AW(8)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .rd(rd), .ra(ra), .rb(rb),
      .imm(imm), .busy(busy), .done(done), .result(result), .flags(flags),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic reset_model();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_flags = 4'b0000;
   endtask

   // Independent model: signed overflow judged from sign-extended 65-bit math
   task automatic model_op(input logic [2:0] o, input logic [4:0] d, input logic [4:0] a_i,
                           input logic [4:0] b_i, input logic [63:0] im, output logic [63:0] r);
      logic [63:0] a, b;
      logic [64:0] w, s;
      logic c, v;
      a = m_regs[a_i];
      b = m_regs[b_i];
      c = 1'b0;
      v = 1'b0;
      r = '0;
      case (o)
         3'd0: r = im;
         3'd1: begin
            w = {1'b0, a} + {1'b0, b};
            r = w[63:0]; c = w[64];
            s = {a[63], a} + {b[63], b};
            v = s[64] ^ s[63];
         end
         3'd2: begin
            r = a - b; c = (a >= b);
            s = {a[63], a} - {b[63], b};
            v = s[64] ^ s[63];
         end
         3'd3: r = a & b;
         3'd4: r = a | b;
         3'd5: r = a ^ b;
         3'd6: r = m_ram[a[7:0]];
         default: begin r = b; m_ram[a[7:0]] = b; end
      endcase
      if (o >= 3'd1 && o <= 3'd5) m_flags = {r == 64'd0, r[63], c, v};
      if (o != 3'd7 && d != 5'd0) m_regs[d] = r;
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge of the done cycle
   task automatic run_op(input logic [2:0] o, input logic [4:0] d, input logic [4:0] a_i,
                         input logic [4:0] b_i, input logic [63:0] im, output int cyc);
      logic [63:0] r, e;
      logic [3:0]  mask;
      model_op(o, d, a_i, b_i, im, r);
      q_exp.push_back(r);
      op = o; rd = d; ra = a_i; rb = b_i; imm = im; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL timeout op=%0d: done not seen within %0d cycles", o, cyc);
         void'(q_exp.pop_front());
      end else begin
         e = q_exp.pop_front();
         mask = (o >= 3'd3 && o <= 3'd5) ? 4'b1101 : 4'b1111;
         if (result !== e) begin
            errors++;
            $display("FAIL result op=%0d: got %h expected %h", o, result, e);
         end
         checks++;
         if ((flags & mask) !== (m_flags & mask)) begin
            errors++;
            $display("FAIL flags op=%0d: got %b expected %b", o, flags, m_flags);
         end
      end
      dbg_sel = d;
      #1;
      checks++;
      if (dbg_data !== m_regs[d]) begin
         errors++;
         $display("FAIL dbg r%0d: got %h expected %h", d, dbg_data, m_regs[d]);
      end
   endtask

   task automatic test_reset();
      int cyc;
      @(negedge clk);
      checks++;
      if ({busy, done, result, flags} !== 70'd0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b result=%h flags=%b, all zero required",
                  busy, done, result, flags);
      end
      rst = 1'b1;
      @(negedge clk);
      run_op(3'd0, 5'd1, 5'd0, 5'd0, 64'h8000_0000_0000_0001, cyc);
      run_op(3'd1, 5'd2, 5'd1, 5'd1, 64'd0, cyc);
      op = 3'd0; rd = 5'd3; imm = 64'h99; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({busy, done, result, flags} !== 70'd0) begin
         errors++;
         $display("FAIL reset_midrun: busy=%b done=%b result=%h flags=%b, all zero required",
                  busy, done, result, flags);
      end
      @(negedge clk);
      rst = 1'b1;
      reset_model();
      for (int i = 1; i < 32; i++) begin
         dbg_sel = 5'(i);
         #1;
         checks++;
         if (dbg_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_reg r%0d: got %h expected 0", i, dbg_data);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_alu();
      int cyc;
      run_op(3'd0, 5'd1, 5'd0, 5'd0, 64'd5, cyc);
      run_op(3'd0, 5'd2, 5'd0, 5'd0, 64'd3, cyc);
      run_op(3'd1, 5'd3, 5'd1, 5'd2, 64'd0, cyc);
      checks++;
      if (cyc !== 4) begin
         errors++;
         $display("FAIL alu_latency: done in cycle %0d expected 4", cyc);
      end
      checks++;
      if (result !== 64'd8 || dbg_data !== 64'd8 || flags !== 4'b0000) begin
         errors++;
         $display("FAIL alu_add: result=%h r3=%h flags=%b expected 8 8 0000", result, dbg_data, flags);
      end
   endtask

   task automatic test_flags();
      int cyc;
      run_op(3'd2, 5'd4, 5'd2, 5'd1, 64'd0, cyc);
      checks++;
      if (result !== 64'hFFFF_FFFF_FFFF_FFFE || flags !== 4'b0100) begin
         errors++;
         $display("FAIL sub_neg: result=%h flags=%b expected fffffffffffffffe 0100", result, flags);
      end
      run_op(3'd0, 5'd5, 5'd0, 5'd0, 64'h7FFF_FFFF_FFFF_FFFF, cyc);
      run_op(3'd0, 5'd11, 5'd0, 5'd0, 64'd1, cyc);
      run_op(3'd1, 5'd12, 5'd5, 5'd11, 64'd0, cyc);
      checks++;
      if (flags !== 4'b0101) begin
         errors++;
         $display("FAIL add_ovf: flags=%b expected 0101", flags);
      end
      run_op(3'd0, 5'd13, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, cyc);
      run_op(3'd1, 5'd14, 5'd13, 5'd11, 64'd0, cyc);
      checks++;
      if (result !== 64'd0 || flags !== 4'b1010) begin
         errors++;
         $display("FAIL add_carry: result=%h flags=%b expected 0 1010", result, flags);
      end
      run_op(3'd0, 5'd15, 5'd0, 5'd0, 64'h1234, cyc);
      checks++;
      if (flags !== 4'b1010) begin
         errors++;
         $display("FAIL loadi_flags: flags=%b expected 1010 unchanged", flags);
      end
      run_op(3'd5, 5'd16, 5'd13, 5'd11, 64'd0, cyc);
      run_op(3'd3, 5'd17, 5'd13, 5'd5, 64'd0, cyc);
      run_op(3'd4, 5'd18, 5'd1, 5'd2, 64'd0, cyc);
      run_op(3'd2, 5'd19, 5'd1, 5'd2, 64'd0, cyc);
   endtask

   task automatic test_memory();
      int cyc;
      run_op(3'd0, 5'd6, 5'd0, 5'd0, 64'h1_0000_0010, cyc);
      run_op(3'd0, 5'd7, 5'd0, 5'd0, 64'hDEAD, cyc);
      run_op(3'd7, 5'd7, 5'd6, 5'd7, 64'd0, cyc);
      checks++;
      if (cyc !== 5) begin
         errors++;
         $display("FAIL st_latency: done in cycle %0d expected 5", cyc);
      end
      run_op(3'd0, 5'd9, 5'd0, 5'd0, 64'h10, cyc);
      run_op(3'd6, 5'd8, 5'd9, 5'd0, 64'd0, cyc);
      checks++;
      if (cyc !== 5 || dbg_data !== 64'hDEAD) begin
         errors++;
         $display("FAIL ld_wrap: cycle=%0d r8=%h expected 5 dead", cyc, dbg_data);
      end
      dbg_sel = 5'd7;
      #1;
      checks++;
      if (dbg_data !== 64'hDEAD) begin
         errors++;
         $display("FAIL st_no_wb: r7=%h expected dead", dbg_data);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      logic [63:0] r;
      int extra;
      run_op(3'd0, 5'd10, 5'd0, 5'd0, 64'd1, cyc);
      // start held high through every busy cycle; only one ADD may run
      model_op(3'd1, 5'd10, 5'd10, 5'd10, 64'd0, r);
      op = 3'd1; rd = 5'd10; ra = 5'd10; rb = 5'd10; start = 1'b1;
      for (int i = 0; i < 4; i++) @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || result !== r) begin
         errors++;
         $display("FAIL held_start: done=%b result=%h expected 1 %h", done, result, r);
      end
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      dbg_sel = 5'd10;
      #1;
      checks++;
      if (extra !== 0 || dbg_data !== 64'd2) begin
         errors++;
         $display("FAIL held_once: extra_busy=%0d r10=%h expected 0 2", extra, dbg_data);
      end
      run_op(3'd0, 5'd20, 5'd0, 5'd0, 64'd7, cyc);
      run_op(3'd1, 5'd21, 5'd20, 5'd10, 64'd0, cyc);
      checks++;
      if (cyc !== 4) begin
         errors++;
         $display("FAIL back_to_back: done in cycle %0d expected 4", cyc);
      end
      run_op(3'd0, 5'd0, 5'd0, 5'd0, 64'h55, cyc);
      checks++;
      if (dbg_data !== 64'd0) begin
         errors++;
         $display("FAIL r0_write: r0=%h expected 0", dbg_data);
      end
   endtask

   task automatic test_abort();
      int cyc;
      run_op(3'd0, 5'd20, 5'd0, 5'd0, 64'h20, cyc);
      run_op(3'd0, 5'd21, 5'd0, 5'd0, 64'hAAAA, cyc);
      run_op(3'd7, 5'd0, 5'd20, 5'd21, 64'd0, cyc);
      run_op(3'd0, 5'd22, 5'd0, 5'd0, 64'hBBBB, cyc);
      op = 3'd7; rd = 5'd0; ra = 5'd20; rb = 5'd22; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0) begin
         errors++;
         $display("FAIL abort: busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
      end
      @(negedge clk);
      rst = 1'b1;
      reset_model();
      @(negedge clk);
      run_op(3'd0, 5'd20, 5'd0, 5'd0, 64'h20, cyc);
      run_op(3'd6, 5'd23, 5'd20, 5'd0, 64'd0, cyc);
      checks++;
      if (dbg_data !== 64'hAAAA) begin
         errors++;
         $display("FAIL abort_ram: r23=%h expected aaaa", dbg_data);
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; op = '0; rd = '0; ra = '0; rb = '0;
      imm = '0; dbg_sel = '0;
      reset_model();
      test_reset();
      test_alu();
      test_flags();
      test_memory();
      test_back_to_back();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/datapath_seq.md
# datapath_seq

Parametrised, self-sequencing datapath: a register file, an ALU with status flags and a single-port word RAM, driven by an internal multi-cycle controller instead of externally driven select and write strobes. A host issues one operation per start pulse and receives a done pulse. It replaces the hand-sequenced 64-bit register-file/ALU/RAM top as the core execution block, with write-back muxing (immediate, ALU, RAM) resolved internally.

## Interface
- DATA_W, 64, datapath and register width
- REG_AW, 5, register index width (2^REG_AW registers)
- RAM_AW, 8, RAM word-address width (2^RAM_AW words of DATA_W)

- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset; asynchronous and active-low
- start  in  1  request; sampled only in IDLE
- op  in  3  0 LOADI, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 LD, 7 ST
- rd, ra, rb  in  REG_AW each  destination, source A, source B
- imm  in  DATA_W  immediate for LOADI
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse on completion
- result  out  DATA_W  last written-back value (ST: stored value)
- flags  out  4  {Z, N, C, V} = flags[3:0]
- dbg_sel  in  REG_AW  debug read index
- dbg_data  out  DATA_W  combinational read of register dbg_sel

## Operation
- Register 0 reads zero; writes to it are discarded. All other registers are general purpose.
- States: IDLE, READ, EXEC, MEM, WB. Each action happens on the edge leaving the named state.
- **IDLE:** if start = 1, latch op, rd, ra, rb, imm; go to READ. Otherwise stay.
- **READ:** A <= reg[ra], B <= reg[rb]; go to EXEC.
- **EXEC:** R <= imm (LOADI) or A op B (ops 1-5); next state is MEM for LD/ST, WB otherwise.
- **MEM:** LD: R <= ram[A[RAM_AW-1:0]] (synchronous read). ST: ram[A[RAM_AW-1:0]] <= B, R <= B. Go to WB.
- **WB:** reg[rd] <= R except for ST; result <= R; done <= 1 for the next cycle; go to IDLE.
- **Addressing:** RAM address is the low RAM_AW bits of A. Upper bits are ignored (wrap).
- **Arithmetic:** modulo 2^DATA_W.
  - ADD: C = carry out.
  - SUB: A + ~B + 1, with C = carry out (1 when A >= B unsigned).
  - V = signed overflow for ADD/SUB; cleared for AND/OR/XOR.
  - Z = (R == 0), N = R[DATA_W-1].
  - Flags update at the EXEC edge for ops 1-5 only. LOADI, LD and ST leave flags unchanged.
- **start while busy:** ignored; no queueing.
- **Reset (rst = 0):** immediately, and asynchronously:
  - state = IDLE, busy = 0, done = 0, result = 0, flags = 0;
  - all registers = 0; A, B, R and latched fields = 0.
  - RAM contents are not reset.
  - An in-flight op aborts. If rst is low before the MEM edge of an ST, no RAM write occurs; no register write occurs for any aborted op.

## Timing
- start high in cycle 0 (IDLE):
  - LOADI and ops 1-5: done high in cycle 4.
  - LD/ST: done high in cycle 5.
- busy is high in cycles 1-3 for ALU/LOADI ops and cycles 1-4 for LD/ST. It is low in the done cycle.
- The done cycle is IDLE, so a start in the done cycle is accepted (back-to-back issue, 4/5-cycle throughput).
- The register written at the WB edge is visible on dbg_data and to a READ in the cycle done is high.
- result and flags hold between operations.
- First active edge after rst deasserts may accept start.

## Test plan
- **Reset:** drive rst = 0 mid-run.
  - Immediately: busy = 0, done = 0, result = 0, flags = 4'b0000.
  - After release: dbg_data = 0 for registers 1..31.
- **ALU timing:** LOADI r1 = 5, LOADI r2 = 3, then ADD r3 = r1 + r2.
  - done in cycle 4 after the ADD start.
  - result = 8, dbg r3 = 8, flags = 4'b0000.
- **Flags:**
  - SUB r4 = r2 - r1 -> 0xFFFFFFFFFFFFFFFE, flags 4'b0100.
  - ADD 0x7FFFFFFFFFFFFFFF + 1 -> flags 4'b0101.
  - ADD 0xFFFFFFFFFFFFFFFF + 1 -> result 0, flags 4'b1010.
  - A following LOADI leaves flags unchanged.
- **Memory:** r6 = 0x100000010, r7 = 0xDEAD, ST (ra = r6, rb = r7); then r9 = 0x10, LD r8 from ra = r9.
  - r8 = 0xDEAD (address wrap), done in cycle 5.
  - r7 unchanged.
- **Handshake:**
  - start pulses in busy cycles are ignored (register values prove only one op ran).
  - start in the done cycle begins the next op; done follows 4 cycles later.
  - LOADI r0 = 0x55 leaves dbg r0 = 0.
- **Abort:** ST to address 0x20 with rst = 0 during MEM.
  - busy drops at once.
  - A subsequent LD from 0x20 returns the previously stored value.
